texture_loader: RTL
===================

Name: texture_loader

Overview:
- CPU-side writer for the 4096 x 3-bit texture RAM, which holds 64 tiles of 8x8 texels at 3 bpp.
- Presents a picosoc iomem slave and unpacks each 32-bit data word into 8 sequential 3-bit texel writes on the RAM write port.
- An auto-incrementing texel pointer and a one-word holding buffer allow back-to-back tile uploads without CPU polling.

Parameters:
- ADDR_W, 12, texel address width; the pointer wraps modulo 2^ADDR_W.
- TEXELS_PER_WORD, 8, texels unpacked per DATA write, taken from wdata[3*TEXELS_PER_WORD-1:0].

Ports:
- clk  in  1  system clock; RAM write port clocked by the same clk.
- resetn  in  1  asynchronous active-low reset.
- iomem_valid  in  1  bus request; already qualified by the address decoder.
- iomem_ready  out  1  one-cycle acknowledge pulse.
- iomem_wstrb  in  4  nonzero = write, zero = read; any nonzero value is a full-word write.
- iomem_addr  in  4  register select on bits [3:2]: 0 ADDR, 1 DATA, 2 STATUS.
- iomem_wdata  in  32  write data.
- iomem_rdata  out  32  read data; valid while iomem_ready=1.
- tex_wen  out  1  RAM write enable.
- tex_waddr  out  ADDR_W  RAM write address.
- tex_wdata  out  3  RAM write data.
- busy  out  1  high while unpacking or while the holding buffer is full.

Behaviour:
- Reset (async, takes effect immediately):
  - iomem_ready=0, iomem_rdata=0, tex_wen=0, tex_waddr=0, tex_wdata=0, busy=0.
  - ptr=0, state IDLE, holding buffer empty.
- Registers:
  - ADDR: write loads ptr from wdata[ADDR_W-1:0]; read returns ptr, zero-extended.
  - DATA: write queues one word; read returns 0.
  - STATUS: read-only. bit31=busy, bit30=hold_full, bits[ADDR_W-1:0]=ptr. Writes are acked and ignored.
- Bus handshake:
  - Accepting edge: valid=1 and the accept condition holds.
  - ready=1 for exactly the cycle after the accepting edge.
  - valid is ignored during the ready cycle (the master drops valid after seeing ready).
  - Reads and STATUS/ignored writes are always accepted: latency 1.
  - DATA write is accepted when the holding buffer is empty. Otherwise ready stays low (stall) until the buffer drains.
  - ADDR write is accepted only when state=IDLE and the holding buffer is empty. Otherwise it stalls.
  - Unknown register (addr[3:2]=3): read returns 0, write ignored, acked with latency 1.
- FSM, states IDLE and UNPACK:
  - IDLE: an accepted DATA word loads the shift register, count=0, and enters UNPACK on the accepting edge.
  - UNPACK, each cycle: tex_wen=1, tex_waddr=ptr, tex_wdata=shift[2:0]; then shift>>=3, ptr=ptr+1 (wrap 4095->0), count++.
  - First tex_wen is in the same cycle as the DATA ready pulse.
  - After write 8 (count=7), holding buffer full: reload the shift register from it, clear the buffer, stay in UNPACK. No bubble: the next texel write follows in the next cycle.
  - After write 8, holding buffer empty: go to IDLE, tex_wen=0.
  - A DATA write accepted while in UNPACK goes to the holding buffer.
  - If the holding buffer drains on the same edge a new DATA write is accepted, the new word goes to the buffer.
- Outputs: all are registered. Exactly 8 writes per word, in increasing address order, low texel first.
- busy = (state==UNPACK) | hold_full.
- Reset mid-unpack: the remaining texels are discarded and the pointer returns to 0. No partial-word recovery.

Optional Feature:
- Macro TEXLOAD_TRANSPARENT_SKIP_EN.
- When defined, a texel value of 0 (transparent) suppresses tex_wen for that slot. ptr, count and timing are unchanged, so existing RAM contents show through.
- When undefined, all 8 slots are written regardless of value.

Test Plan:
- Reset, then write ADDR=0x040 and DATA=0x00FAC688 -> ready pulse; tex_wen for 8 consecutive cycles at addresses 0x040..0x047 with data 0,1,2,3,4,5,6,7; then tex_wen=0, busy=0; STATUS reads 0x00000048.
- Write ADDR=0xFFC, then DATA=0x00FFFFFF -> writes of 7 at 0xFFC..0xFFF, then 0x000..0x003; final ptr=0x004.
- Three DATA writes issued back-to-back -> 1st and 2nd acked immediately; 3rd stalls until the 1st finishes; 24 contiguous tex_wen cycles with no gap; addresses increment by 24.
- ADDR write issued during unpack -> ready held low until busy=0; subsequent texel writes use the new address.
- Assert resetn low in the 4th cycle of unpack -> tex_wen drops immediately; after release STATUS=0 and there are no further writes.
- With TEXLOAD_TRANSPARENT_SKIP_EN defined, DATA=0x00FAC688 at ADDR=0 -> only addresses 1..7 written; address 0 untouched; ptr=8.

Source files
------------

// File: rtl/texture_loader.sv
// texture_loader: picosoc iomem slave that unpacks 32-bit words into 3-bit texel writes for the texture RAM.
// Define TEXLOAD_TRANSPARENT_SKIP_EN to suppress writes of transparent (zero) texels.
module texture_loader #(
  parameter int ADDR_W = 12,
  parameter int TEXELS_PER_WORD = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              iomem_valid,
  output logic              iomem_ready,
  input  logic [3:0]        iomem_wstrb,
  input  logic [3:0]        iomem_addr,
  input  logic [31:0]       iomem_wdata,
  output logic [31:0]       iomem_rdata,
  output logic              tex_wen,
  output logic [ADDR_W-1:0] tex_waddr,
  output logic [2:0]        tex_wdata,
  output logic              busy
);
  localparam int SW = 3 * TEXELS_PER_WORD;
  localparam int CW = $clog2(TEXELS_PER_WORD + 1);
  typedef enum logic {IDLE, UNPACK} state_t;
  state_t state, state_n;
  logic [SW-1:0] shift, hold, src;
  logic [CW-1:0] count;
  logic [ADDR_W-1:0] ptr, ptr_n;
  logic [1:0] sel;
  logic [31:0] rd;
  logic hold_full, hold_full_n, wr, acc, data_acc, last, emit, wen_n;
  logic unused_bits;
  assign unused_bits = ^{iomem_addr[1:0], iomem_wdata[31:SW]};
  always_comb begin
    sel = iomem_addr[3:2];
    wr = |iomem_wstrb;
    acc = iomem_valid && !iomem_ready && (!wr || sel[1] || (!hold_full && (sel[0] || state == IDLE)));
    data_acc = acc && wr && sel == 2'd1;
    last = state == UNPACK && count == CW'(TEXELS_PER_WORD);
    // a word arriving on the final texel chains straight into the next word
    emit = state == IDLE ? data_acc : (!last || hold_full || data_acc);
    src = (state == IDLE || (last && !hold_full)) ? iomem_wdata[SW-1:0] : last ? hold : shift;
    state_n = emit ? UNPACK : IDLE;
    hold_full_n = (last && hold_full) ? 1'b0 : (state == UNPACK && data_acc && !last) ? 1'b1 : hold_full;
    ptr_n = emit ? ptr + 1'b1 : (acc && wr && sel == 2'd0) ? iomem_wdata[ADDR_W-1:0] : ptr;
    rd = (!wr && sel == 2'd0) ? 32'(ptr) : (!wr && sel == 2'd2) ? {busy, hold_full, 30'(ptr)} : '0;
`ifdef TEXLOAD_TRANSPARENT_SKIP_EN
    wen_n = emit && src[2:0] != 3'd0;
`else
    wen_n = emit;
`endif
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      shift <= '0;
      hold <= '0;
      hold_full <= 1'b0;
      count <= '0;
      ptr <= '0;
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
      tex_wen <= 1'b0;
      tex_waddr <= '0;
      tex_wdata <= '0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      shift <= src >> 3;
      hold <= data_acc ? iomem_wdata[SW-1:0] : hold;
      hold_full <= hold_full_n;
      count <= (state == IDLE || last) ? CW'(1) : count + 1'b1;
      ptr <= ptr_n;
      iomem_ready <= acc;
      iomem_rdata <= acc ? rd : '0;
      tex_wen <= wen_n;
      tex_waddr <= emit ? ptr : tex_waddr;
      tex_wdata <= emit ? src[2:0] : tex_wdata;
      busy <= emit || hold_full_n;
    end
  end
endmodule
